// File: rtl/sdram_rcache_wb.sv
// Direct-mapped, one-word-per-line read cache in front of the SDRAM Wishbone controller.
// Read hits ack in one cycle; writes always go through and update only lines already cached.
module sdram_rcache_wb #(
    parameter int unsigned ADDR_WIDTH = 25,
    parameter int unsigned IDX_BITS   = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic [ADDR_WIDTH-1:0] s_adr_i,
    input  logic [31:0]           s_dat_i,
    output logic [31:0]           s_dat_o,
    input  logic                  s_we_i,
    input  logic [3:0]            s_sel_i,
    input  logic                  s_stb_i,
    input  logic                  s_cyc_i,
    output logic                  s_ack_o,
    output logic [ADDR_WIDTH-1:0] m_adr_o,
    output logic [31:0]           m_dat_o,
    input  logic [31:0]           m_dat_i,
    output logic                  m_we_o,
    output logic [3:0]            m_sel_o,
    output logic                  m_stb_o,
    output logic                  m_cyc_o,
    input  logic                  m_ack_i,
    input  logic                  flush_i
);

    localparam int unsigned LINES = 32'(1) << IDX_BITS;
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_BITS - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_MISS,
        S_WR_THRU,
        S_ACK
    } state_e;

    state_e                  state_q;
    logic                    abort_q;
    logic                    s_ack_q;
    logic [31:0]             s_dat_q;
    logic [ADDR_WIDTH-1:0]   m_adr_q;
    logic [31:0]             m_dat_q;
    logic [3:0]              m_sel_q;
    logic                    m_we_q;
    logic                    m_stb_q;
    logic [LINES-1:0]        valid_q;
    logic [LINES-1:0]        valid_d;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [31:0]             data_mem [LINES];

    logic [IDX_BITS-1:0]     s_idx_c;
    logic [IDX_BITS-1:0]     m_idx_c;
    logic [TAG_W-1:0]        s_tag_c;
    logic [TAG_W-1:0]        m_tag_c;
    logic                    req_c;
    logic                    hit_c;
    logic                    fill_c;
    logic                    merge_c;
    logic [31:0]             merged_c;
    logic                    unused_c;

    assign s_idx_c  = s_adr_i[IDX_BITS+1:2];
    assign s_tag_c  = s_adr_i[ADDR_WIDTH-1:IDX_BITS+2];
    assign m_idx_c  = m_adr_q[IDX_BITS+1:2];
    assign m_tag_c  = m_adr_q[ADDR_WIDTH-1:IDX_BITS+2];
    assign unused_c = ^s_adr_i[1:0];

    assign req_c   = s_cyc_i & s_stb_i;
    assign hit_c   = valid_q[s_idx_c] && (tag_mem[s_idx_c] == s_tag_c);
    assign fill_c  = (state_q == S_RD_MISS) && m_ack_i;
    assign merge_c = (state_q == S_WR_THRU) && m_ack_i
                     && valid_q[m_idx_c] && (tag_mem[m_idx_c] == m_tag_c);

    // Byte-merge of the write-through data into the cached word
    always_comb begin
        merged_c = data_mem[m_idx_c];
        for (int b = 0; b < 4; b++) begin
            if (m_sel_q[b]) begin
                merged_c[8*b +: 8] = m_dat_q[8*b +: 8];
            end
        end
    end

    // Flush overrides a coincident fill so the line is left invalid
    always_comb begin
        valid_d = valid_q;
        if (fill_c) begin
            valid_d[m_idx_c] = 1'b1;
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (fill_c) begin
            data_mem[m_idx_c] <= m_dat_i;
            tag_mem[m_idx_c]  <= m_tag_c;
        end else if (merge_c) begin
            data_mem[m_idx_c] <= merged_c;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            abort_q <= 1'b0;
            s_ack_q <= 1'b0;
            s_dat_q <= '0;
            m_adr_q <= '0;
            m_dat_q <= '0;
            m_sel_q <= 4'h0;
            m_we_q  <= 1'b0;
            m_stb_q <= 1'b0;
            valid_q <= '0;
        end else begin
            s_ack_q <= 1'b0;
            valid_q <= valid_d;
            case (state_q)
                S_IDLE: begin
                    abort_q <= 1'b0;
                    if (req_c) begin
                        if (s_we_i) begin
                            m_adr_q <= {s_adr_i[ADDR_WIDTH-1:2], 2'b00};
                            m_dat_q <= s_dat_i;
                            m_sel_q <= s_sel_i;
                            m_we_q  <= 1'b1;
                            m_stb_q <= 1'b1;
                            state_q <= S_WR_THRU;
                        end else if (hit_c) begin
                            s_dat_q <= data_mem[s_idx_c];
                            s_ack_q <= 1'b1;
                            state_q <= S_ACK;
                        end else begin
                            m_adr_q <= {s_adr_i[ADDR_WIDTH-1:2], 2'b00};
                            m_sel_q <= 4'hF;
                            m_we_q  <= 1'b0;
                            m_stb_q <= 1'b1;
                            state_q <= S_RD_MISS;
                        end
                    end
                end
                S_RD_MISS, S_WR_THRU: begin
                    if (!s_cyc_i) begin
                        abort_q <= 1'b1;
                    end
                    // SDRAM cycle is completed even when the CPU has walked away
                    if (m_ack_i) begin
                        m_stb_q <= 1'b0;
                        m_we_q  <= 1'b0;
                        if (state_q == S_RD_MISS) begin
                            s_dat_q <= m_dat_i;
                        end
                        if (abort_q || !s_cyc_i) begin
                            state_q <= S_IDLE;
                        end else begin
                            s_ack_q <= 1'b1;
                            state_q <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign s_ack_o = s_ack_q;
    assign s_dat_o = s_dat_q;
    assign m_adr_o = m_adr_q;
    assign m_dat_o = m_dat_q;
    assign m_sel_o = m_sel_q;
    assign m_we_o  = m_we_q;
    assign m_stb_o = m_stb_q;
    assign m_cyc_o = m_stb_q;

endmodule

// File: tb/tb_sdram_rcache_wb.sv
// Directed bench for sdram_rcache_wb: CPU driver, SDRAM responder model, and an
// ack monitor that pops expected read data from a scoreboard queue.
module tb_sdram_rcache_wb;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [24:0] s_adr_i;
    logic [31:0] s_dat_i;
    logic [31:0] s_dat_o;
    logic        s_we_i;
    logic [3:0]  s_sel_i;
    logic        s_stb_i;
    logic        s_cyc_i;
    logic        s_ack_o;
    logic [24:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic        m_stb_o;
    logic        m_cyc_o;
    logic        m_ack_i;
    logic        flush_i;

    always #5 clk = ~clk;

    sdram_rcache_wb dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .s_adr_i  (s_adr_i),
        .s_dat_i  (s_dat_i),
        .s_dat_o  (s_dat_o),
        .s_we_i   (s_we_i),
        .s_sel_i  (s_sel_i),
        .s_stb_i  (s_stb_i),
        .s_cyc_i  (s_cyc_i),
        .s_ack_o  (s_ack_o),
        .m_adr_o  (m_adr_o),
        .m_dat_o  (m_dat_o),
        .m_dat_i  (m_dat_i),
        .m_we_o   (m_we_o),
        .m_sel_o  (m_sel_o),
        .m_stb_o  (m_stb_o),
        .m_cyc_o  (m_cyc_o),
        .m_ack_i  (m_ack_i),
        .flush_i  (flush_i)
    );

    typedef struct {
        logic        chk;
        logic [31:0] dat;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Shared between CPU driver (writer) and SDRAM model (reader)
    int          ack_extra   = 0;
    int          flush_req   = 0;
    int          flush_fill  = 0;
    // Written only by the SDRAM model
    int          tx_cnt = 0;
    logic        last_we;
    logic [3:0]  last_sel;
    logic [24:0] last_adr;
    logic [31:0] last_dat;
    logic [31:0] sdram [logic [24:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sdram_rd(input logic [24:0] a);
        if (sdram.exists(a)) return sdram[a];
        return 32'hA500_0000 ^ 32'(a);
    endfunction

    // SDRAM responder: acks LAT cycles into a strobe, optionally holding ack extra cycles
    initial begin : sdram_model
        int wait_c;
        int persist;
        int flush_seen;
        int fill_seen;
        logic [31:0] w;
        wait_c = 0; persist = 0; flush_seen = 0; fill_seen = 0;
        m_ack_i = 1'b0; m_dat_i = '0; flush_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            flush_i = 1'b0;
            if (flush_req != flush_seen) begin
                flush_i = 1'b1;
                flush_seen = flush_req;
            end
            if (m_ack_i && persist > 0) begin
                persist--;
            end else begin
                m_ack_i = 1'b0;
                if (m_stb_o) begin
                    wait_c++;
                    if (wait_c >= LAT) begin
                        wait_c   = 0;
                        tx_cnt++;
                        last_we  = m_we_o;
                        last_sel = m_sel_o;
                        last_adr = m_adr_o;
                        last_dat = m_dat_o;
                        if (m_we_o) begin
                            w = sdram_rd(m_adr_o);
                            for (int b = 0; b < 4; b++)
                                if (m_sel_o[b]) w[8*b +: 8] = m_dat_o[8*b +: 8];
                            sdram[m_adr_o] = w;
                        end else begin
                            m_dat_i = sdram_rd(m_adr_o);
                        end
                        m_ack_i = 1'b1;
                        persist = ack_extra;
                        if (flush_fill != fill_seen) begin
                            flush_i   = 1'b1;
                            fill_seen = flush_fill;
                        end
                    end
                end else begin
                    wait_c = 0;
                end
            end
        end
    end

    // Monitor: every CPU ack must match the oldest outstanding expectation
    always @(negedge clk) begin : ack_monitor
        exp_t e;
        if (rst_n === 1'b1 && s_ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(s_ack_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (e.chk) check(e.name, s_dat_o, e.dat);
            end
        end
    end

    task automatic cpu_req(input logic we, input logic [24:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] exp_dat,
                           input logic exp_miss, input string name);
        int   tx0;
        int   lat;
        exp_t e;
        e.chk = !we; e.dat = exp_dat; e.name = name;
        exp_q.push_back(e);
        tx0 = tx_cnt;
        @(posedge clk); #1;
        s_adr_i = adr; s_dat_i = dat; s_we_i = we; s_sel_i = sel;
        s_cyc_i = 1'b1; s_stb_i = 1'b1;
        lat = -1;
        do begin
            @(negedge clk);
            lat++;
        end while (s_ack_o !== 1'b1 && lat < 60);
        if (s_ack_o !== 1'b1) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
            exp_q.delete();
        end
        @(posedge clk); #1;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        check({name, "_sdram_tx"}, 32'(tx_cnt - tx0), exp_miss ? 32'd1 : 32'd0);
        if (!exp_miss) check({name, "_hit_latency"}, 32'(lat), 32'd1);
        if (exp_miss) begin
            check({name, "_m_we"},  32'(last_we),  32'(we));
            check({name, "_m_sel"}, 32'(last_sel), we ? 32'(sel) : 32'hF);
            check({name, "_m_adr"}, 32'(last_adr), 32'({adr[24:2], 2'b00}));
            if (we) check({name, "_m_dat"}, last_dat, dat);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ack"}, 32'(s_ack_o), 32'd0);
        check({tag, "_m_stb"}, 32'(m_stb_o), 32'd0);
        check({tag, "_m_cyc"}, 32'(m_cyc_o), 32'd0);
        check({tag, "_m_we"},  32'(m_we_o),  32'd0);
        check({tag, "_s_dat"}, s_dat_o,      32'd0);
        check({tag, "_m_adr"}, 32'(m_adr_o), 32'd0);
        check({tag, "_m_dat"}, m_dat_o,      32'd0);
        check({tag, "_m_sel"}, 32'(m_sel_o), 32'd0);
    endtask

    initial begin : stimulus
        int tx0;
        rst_n = 1'b0;
        s_adr_i = '0; s_dat_i = '0; s_we_i = 1'b0; s_sel_i = 4'h0;
        s_stb_i = 1'b0; s_cyc_i = 1'b0;
        sdram[25'h000040] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: miss (with a lingering controller ack) then a 1-cycle hit
        ack_extra = 1;
        cpu_req(1'b0, 25'h000040, '0, 4'hF, 32'hDEADBEEF, 1'b1, "c1_miss");
        ack_extra = 0;
        cpu_req(1'b0, 25'h000040, '0, 4'hF, 32'hDEADBEEF, 1'b0, "c1_hit");

        // 2: write-through merges selected bytes into the cached word
        cpu_req(1'b1, 25'h000040, 32'h11223344, 4'b0011, '0, 1'b1, "c2_wr");
        cpu_req(1'b0, 25'h000040, '0, 4'hF, 32'hDEAD3344, 1'b0, "c2_hit");

        // 3: write to an uncached word does not allocate (0x80 shares index 0)
        cpu_req(1'b1, 25'h000080, 32'hCAFEF00D, 4'hF, '0, 1'b1, "c3_wr");
        cpu_req(1'b0, 25'h000080, '0, 4'hF, 32'hCAFEF00D, 1'b1, "c3_rd_miss");

        // 4: aliasing on index 0, then flush
        cpu_req(1'b0, 25'h000040, '0, 4'hF, 32'hDEAD3344, 1'b1, "c4_rd40");
        cpu_req(1'b0, 25'h000400, '0, 4'hF, 32'hA5000400, 1'b1, "c4_rd400");
        cpu_req(1'b0, 25'h000040, '0, 4'hF, 32'hDEAD3344, 1'b1, "c4_rd40_again");
        cpu_req(1'b0, 25'h000400, '0, 4'hF, 32'hA5000400, 1'b1, "c4_rd400_fill");
        cpu_req(1'b0, 25'h000400, '0, 4'hF, 32'hA5000400, 1'b0, "c4_rd400_hit");
        flush_req++;
        repeat (3) @(posedge clk);
        cpu_req(1'b0, 25'h000400, '0, 4'hF, 32'hA5000400, 1'b1, "c4_after_flush");

        // 5a: abort mid-miss: no ack, but the line is still filled
        tx0 = tx_cnt;
        @(posedge clk); #1;
        s_adr_i = 25'h001004; s_we_i = 1'b0; s_sel_i = 4'hF; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        repeat (8) @(posedge clk);
        check("c5_abort_sdram_tx", 32'(tx_cnt - tx0), 32'd1);
        cpu_req(1'b0, 25'h001004, '0, 4'hF, 32'hA5001004, 1'b0, "c5_abort_then_hit");

        // 5b: flush coinciding with the fill ack: data returned, line stays invalid
        flush_fill++;
        cpu_req(1'b0, 25'h002008, '0, 4'hF, 32'hA5002008, 1'b1, "c5_flush_fill");
        cpu_req(1'b0, 25'h002008, '0, 4'hF, 32'hA5002008, 1'b1, "c5_after_flush_fill");

        // 6: async reset in the middle of a miss
        @(posedge clk); #1;
        s_adr_i = 25'h00300C; s_we_i = 1'b0; s_sel_i = 4'hF; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("c6_stb_before_reset", 32'(m_stb_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("c6_stb_in_reset", 32'(m_stb_o), 32'd0);
        check("c6_cyc_in_reset", 32'(m_cyc_o), 32'd0);
        @(posedge clk); #1;
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        check("c6_no_ack_queue", 32'(exp_q.size()), 32'd0);
        cpu_req(1'b0, 25'h002008, '0, 4'hF, 32'hA5002008, 1'b1, "c6_first_read_misses");
        cpu_req(1'b0, 25'h001004, '0, 4'hF, 32'hA5001004, 1'b1, "c6_old_line_invalid");

        repeat (5) @(posedge clk);
        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
